// File: rtl/dmem_arbiter.sv
// Single-port data RAM arbiter between the core MEM stage and the io block, with starvation guard and read-return routing.
// Optional grant/conflict statistics are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter #(
  parameter int AW         = 32,
  parameter int RD_LAT     = 1,
  parameter int MAX_STREAK = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [31:0]   core_wdata,
  output logic          core_gnt,
  output logic          core_stall,
  output logic          core_rvalid,
  output logic [31:0]   core_rdata,
  input  logic          io_req,
  input  logic          io_we,
  input  logic [AW-1:0] io_addr,
  input  logic [31:0]   io_wdata,
  output logic          io_gnt,
  output logic          io_rvalid,
  output logic [31:0]   io_rdata,
  input  logic          io_excl,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic [31:0]   stat_core_gnts,
  output logic [31:0]   stat_io_gnts,
  output logic [31:0]   stat_conflicts
);

  typedef enum logic [1:0] {
    S_CORE    = 2'd0,
    S_IO_FAIR = 2'd1,
    S_IO_HOLD = 2'd2
  } state_t;

  localparam int            SW          = $clog2(MAX_STREAK) + 1;
  localparam logic [SW-1:0] STREAK_LAST = SW'(MAX_STREAK - 1);

  state_t        state, state_nxt;
  logic [SW-1:0] streak, streak_nxt;
  logic          rd_issue;
  logic [RD_LAT-1:0] rd_vld_p;
  logic [RD_LAT-1:0] rd_own_p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_CORE;
      streak <= '0;
    end else begin
      state  <= state_nxt;
      streak <= streak_nxt;
    end
  end

  // Streak only grows while io is actually waiting behind a core grant.
  always_comb begin
    state_nxt  = state;
    streak_nxt = streak;
    if (io_excl) begin
      state_nxt  = S_IO_HOLD;
      streak_nxt = '0;
    end else begin
      case (state)
        S_CORE: begin
          if (core_gnt && io_req) begin
            if (streak == STREAK_LAST) begin
              state_nxt  = S_IO_FAIR;
              streak_nxt = '0;
            end else begin
              streak_nxt = streak + 1'b1;
            end
          end else if (io_gnt || !io_req) begin
            streak_nxt = '0;
          end
        end
        S_IO_FAIR: begin
          if (io_gnt || !io_req) state_nxt = S_CORE;
          streak_nxt = '0;
        end
        S_IO_HOLD: begin
          state_nxt  = S_CORE;
          streak_nxt = '0;
        end
        default: begin
          state_nxt  = S_CORE;
          streak_nxt = '0;
        end
      endcase
    end
  end

  always_comb begin
    core_gnt = 1'b0;
    io_gnt   = 1'b0;
    case (state)
      S_CORE: begin
        core_gnt = core_req;
        io_gnt   = io_req & ~core_req;
      end
      S_IO_FAIR: begin
        io_gnt   = io_req;
        core_gnt = core_req & ~io_req;
      end
      S_IO_HOLD: io_gnt = io_req;
      default: ;
    endcase
  end

  always_comb begin
    mem_en    = core_gnt | io_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (core_gnt) begin
      mem_we    = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end else if (io_gnt) begin
      mem_we    = io_we;
      mem_addr  = io_addr;
      mem_wdata = io_wdata;
    end
  end

  assign core_stall = core_req & ~core_gnt;
  assign rd_issue   = mem_en & ~mem_we;

  // Read-owner pipe: stage 0 is loaded on the issue edge, last stage lines up with mem_rdata.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld_p <= '0;
      rd_own_p <= '0;
    end else begin
      rd_vld_p[0] <= rd_issue;
      rd_own_p[0] <= io_gnt;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_vld_p[i] <= rd_vld_p[i-1];
        rd_own_p[i] <= rd_own_p[i-1];
      end
    end
  end

  assign core_rvalid = rd_vld_p[RD_LAT-1] & ~rd_own_p[RD_LAT-1];
  assign io_rvalid   = rd_vld_p[RD_LAT-1] &  rd_own_p[RD_LAT-1];
  assign core_rdata  = core_rvalid ? mem_rdata : 32'h0;
  assign io_rdata    = io_rvalid   ? mem_rdata : 32'h0;

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] core_gnts_q, io_gnts_q, conflicts_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_gnts_q <= '0;
      io_gnts_q   <= '0;
      conflicts_q <= '0;
    end else begin
      core_gnts_q <= sat_inc(core_gnts_q, core_gnt);
      io_gnts_q   <= sat_inc(io_gnts_q, io_gnt);
      conflicts_q <= sat_inc(conflicts_q, core_req & io_req);
    end
  end

  assign stat_core_gnts = core_gnts_q;
  assign stat_io_gnts   = io_gnts_q;
  assign stat_conflicts = conflicts_q;
`else
  assign stat_core_gnts = 32'h0;
  assign stat_io_gnts   = 32'h0;
  assign stat_conflicts = 32'h0;
`endif

endmodule
